// File: rtl/dac_update_scheduler.sv
// Write sequencer for the two-channel laser-bias DAC: ramps each channel toward its target in
// bounded steps, alternates between channels, spaces writes apart and gives laser-off priority.
module dac_update_scheduler #(
    parameter logic [11:0] STEP           = 12'd64,
    parameter logic [15:0] GAP_CYCLES     = 16'd200,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        DAWrFinishFlag,
    input  logic        ch1_set,
    input  logic [11:0] ch1_target,
    input  logic        ch2_set,
    input  logic [11:0] ch2_target,
    input  logic        laser_off_req,
    output logic        LD650_1DACStartFlag,
    output logic        LD650_2DACStartFlag,
    output logic [11:0] LD650_1DACData,
    output logic [11:0] LD650_2DACData,
    output logic        LD650_1LaserOffFlag,
    output logic        ready,
    output logic        ch1_at_target,
    output logic        ch2_at_target,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        S_INIT_WAIT = 3'd0,
        S_IDLE      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4,
        S_OFF_ISSUE = 3'd5,
        S_OFF_WAIT  = 3'd6
    } state_t;

    state_t      r_state;
    logic [11:0] r_cur1, r_cur2, r_tgt1, r_tgt2, r_data1, r_data2, r_next;
    logic        r_start1, r_start2, r_off_flag, r_ready, r_err;
    logic        r_sel;       // 0 = ch1, 1 = ch2
    logic        r_last;      // channel served by the most recent completed write
    logic        r_off_pend;
    logic        r_fin_cnt;   // first of the two init-frame finish pulses seen
    logic [15:0] r_cnt;

    logic        w_pend1, w_pend2, w_sel, w_timeout, w_gap_done;
    logic [11:0] w_next;

    function automatic logic [11:0] f_step(input logic [11:0] cur, input logic [11:0] tgt);
        logic [11:0] diff;
        logic [11:0] res;
        if (tgt >= cur) begin
            diff = tgt - cur;
            if (diff <= STEP) res = tgt;
            else              res = cur + STEP;
        end else begin
            diff = cur - tgt;
            if (diff <= STEP) res = tgt;
            else              res = cur - STEP;
        end
        return res;
    endfunction

    // Pending detection, round-robin choice and next code for the chosen channel
    always_comb begin
        w_pend1    = (r_cur1 != r_tgt1);
        w_pend2    = (r_cur2 != r_tgt2);
        w_timeout  = ((r_cnt + 16'd1) >= TIMEOUT_CYCLES);
        w_gap_done = ((r_cnt + 16'd1) >= GAP_CYCLES);
        if (w_pend1 && w_pend2) w_sel = ~r_last;
        else                    w_sel = w_pend2;
        if (w_sel) w_next = f_step(r_cur2, r_tgt2);
        else       w_next = f_step(r_cur1, r_tgt1);
    end

    // Scheduler state machine with registered flags and data
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= S_INIT_WAIT;
            r_cur1     <= 12'd0;
            r_cur2     <= 12'd0;
            r_tgt1     <= 12'd0;
            r_tgt2     <= 12'd0;
            r_data1    <= 12'd0;
            r_data2    <= 12'd0;
            r_next     <= 12'd0;
            r_start1   <= 1'b0;
            r_start2   <= 1'b0;
            r_off_flag <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_sel      <= 1'b0;
            r_last     <= 1'b1;
            r_off_pend <= 1'b0;
            r_fin_cnt  <= 1'b0;
            r_cnt      <= 16'd0;
        end else begin
            r_start1   <= 1'b0;
            r_start2   <= 1'b0;
            r_off_flag <= 1'b0;
            // An off request in the same cycle as a set wins; the set is dropped
            if (laser_off_req) begin
                r_off_pend <= 1'b1;
            end else begin
                if (ch1_set) r_tgt1 <= ch1_target;
                if (ch2_set) r_tgt2 <= ch2_target;
            end
            case (r_state)
                S_INIT_WAIT: begin
                    if (DAWrFinishFlag) begin
                        if (r_fin_cnt) begin
                            r_fin_cnt <= 1'b0;
                            r_ready   <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_fin_cnt <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (r_off_pend || laser_off_req) begin
                        r_off_flag <= 1'b1;
                        r_tgt1     <= 12'd0;
                        r_tgt2     <= 12'd0;
                        r_data1    <= 12'd0;
                        r_data2    <= 12'd0;
                        r_ready    <= 1'b0;
                        r_state    <= S_OFF_ISSUE;
                    end else if (w_pend1 || w_pend2) begin
                        r_sel   <= w_sel;
                        r_next  <= w_next;
                        r_ready <= 1'b0;
                        if (w_sel) begin
                            r_data2  <= w_next;
                            r_start2 <= 1'b1;
                        end else begin
                            r_data1  <= w_next;
                            r_start1 <= 1'b1;
                        end
                        r_state <= S_ISSUE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= 16'd0;
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (DAWrFinishFlag) begin
                        if (r_sel) r_cur2 <= r_next;
                        else       r_cur1 <= r_next;
                        r_last  <= r_sel;
                        r_cnt   <= 16'd0;
                        r_state <= S_GAP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_cnt   <= 16'd0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (w_gap_done) begin
                        r_cnt   <= 16'd0;
                        r_ready <= !(w_pend1 || w_pend2 || r_off_pend);
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_OFF_ISSUE: begin
                    r_tgt1     <= 12'd0;
                    r_tgt2     <= 12'd0;
                    r_off_pend <= 1'b0;
                    r_fin_cnt  <= 1'b0;
                    r_cnt      <= 16'd0;
                    r_state    <= S_OFF_WAIT;
                end
                S_OFF_WAIT: begin
                    if (DAWrFinishFlag) begin
                        r_cnt <= 16'd0;
                        if (r_fin_cnt) begin
                            r_fin_cnt <= 1'b0;
                            r_cur1    <= 12'd0;
                            r_cur2    <= 12'd0;
                            r_state   <= S_GAP;
                        end else begin
                            r_fin_cnt <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_err     <= 1'b1;
                        r_fin_cnt <= 1'b0;
                        r_cnt     <= 16'd0;
                        r_state   <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_INIT_WAIT;
                end
            endcase
        end
    end

    assign LD650_1DACStartFlag = r_start1;
    assign LD650_2DACStartFlag = r_start2;
    assign LD650_1DACData      = r_data1;
    assign LD650_2DACData      = r_data2;
    assign LD650_1LaserOffFlag = r_off_flag;
    assign ready               = r_ready;
    assign err_timeout         = r_err;
    assign ch1_at_target       = (r_cur1 == r_tgt1);
    assign ch2_at_target       = (r_cur2 == r_tgt2);

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler: a DAC-controller responder acknowledges writes, a monitor logs
// every flag, and each scenario compares the log against a step/round-robin reference model.
module tb_dac_update_scheduler;

    localparam int STEP_I = 64;
    localparam int GAP_I  = 20;
    localparam int TMO_I  = 100;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        DAWrFinishFlag;
    logic        ch1_set = 1'b0, ch2_set = 1'b0, laser_off_req = 1'b0;
    logic [11:0] ch1_target = 12'd0, ch2_target = 12'd0;
    logic        LD650_1DACStartFlag, LD650_2DACStartFlag, LD650_1LaserOffFlag;
    logic [11:0] LD650_1DACData, LD650_2DACData;
    logic        ready, ch1_at_target, ch2_at_target, err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int init_req = 0;
    int init_served = 0;
    bit ack_en = 1'b1;

    int          wr_ch[$];
    logic [11:0] wr_data[$];
    int          wr_cyc[$];
    int          off_cnt = 0;
    int          off_cyc = 0;
    int          multi_cnt = 0;

    int exp_ch[$];
    int exp_data[$];
    int m_cur1, m_cur2, m_last;

    dac_update_scheduler #(
        .STEP(12'd64), .GAP_CYCLES(16'd20), .TIMEOUT_CYCLES(16'd100)
    ) dut (
        .clk(clk), .Reset(Reset), .DAWrFinishFlag(DAWrFinishFlag),
        .ch1_set(ch1_set), .ch1_target(ch1_target),
        .ch2_set(ch2_set), .ch2_target(ch2_target),
        .laser_off_req(laser_off_req),
        .LD650_1DACStartFlag(LD650_1DACStartFlag), .LD650_2DACStartFlag(LD650_2DACStartFlag),
        .LD650_1DACData(LD650_1DACData), .LD650_2DACData(LD650_2DACData),
        .LD650_1LaserOffFlag(LD650_1LaserOffFlag), .ready(ready),
        .ch1_at_target(ch1_at_target), .ch2_at_target(ch2_at_target),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every write request and off request seen by the DAC controller
    initial begin
        forever begin
            @(negedge clk);
            if (!Reset) begin
                if ((int'(LD650_1DACStartFlag) + int'(LD650_2DACStartFlag) + int'(LD650_1LaserOffFlag)) > 1)
                    multi_cnt++;
                if (LD650_1DACStartFlag) begin
                    wr_ch.push_back(1); wr_data.push_back(LD650_1DACData); wr_cyc.push_back(cyc);
                end
                if (LD650_2DACStartFlag) begin
                    wr_ch.push_back(2); wr_data.push_back(LD650_2DACData); wr_cyc.push_back(cyc);
                end
                if (LD650_1LaserOffFlag) begin
                    off_cnt++; off_cyc = cyc;
                end
            end
        end
    end

    task automatic pulse_finish();
        DAWrFinishFlag = 1'b1;
        @(negedge clk);
        DAWrFinishFlag = 1'b0;
    endtask

    // DAC controller model: init frames on request, finish pulse 3 cycles after each start
    initial begin
        DAWrFinishFlag = 1'b0;
        forever begin
            @(negedge clk);
            if (init_served != init_req) begin
                repeat (2) @(negedge clk);
                pulse_finish();
                repeat (3) @(negedge clk);
                pulse_finish();
                init_served = init_req;
            end else if (ack_en && (LD650_1DACStartFlag || LD650_2DACStartFlag)) begin
                repeat (3) @(negedge clk);
                pulse_finish();
            end else if (ack_en && LD650_1LaserOffFlag) begin
                repeat (3) @(negedge clk);
                pulse_finish();
                repeat (3) @(negedge clk);
                pulse_finish();
            end
        end
    end

    function automatic int step_toward(input int c, input int t);
        if (t > c) return ((t - c) <= STEP_I) ? t : c + STEP_I;
        else       return ((c - t) <= STEP_I) ? t : c - STEP_I;
    endfunction

    // Reference: expected (channel, code) list until both channels reach their targets
    task automatic model_build(input int c1, input int t1, input int c2, input int t2, inout int last);
        exp_ch.delete();
        exp_data.delete();
        while (c1 != t1 || c2 != t2) begin
            int s;
            if (c1 != t1 && c2 != t2) s = (last == 1) ? 2 : 1;
            else                      s = (c1 != t1) ? 1 : 2;
            if (s == 1) begin c1 = step_toward(c1, t1); exp_data.push_back(c1); end
            else        begin c2 = step_toward(c2, t2); exp_data.push_back(c2); end
            exp_ch.push_back(s);
            last = s;
        end
    endtask

    task automatic set_targets(input bit s1, input logic [11:0] t1, input bit s2, input logic [11:0] t2);
        @(negedge clk);
        ch1_target = t1; ch2_target = t2; ch1_set = s1; ch2_set = s2;
        @(negedge clk);
        ch1_set = 1'b0; ch2_set = 1'b0;
    endtask

    task automatic wait_init(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (init_served == init_req) begin ok = 1'b1; break; end
        end
        @(negedge clk);
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        repeat (3) @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (wr_ch.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic do_reset_init(output bit ok);
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        init_req++;
        wait_init(ok);
        m_cur1 = 0; m_cur2 = 0; m_last = 2;
    endtask

    task automatic test_reset();
        bit ok;
        Reset = 1'b1;
        repeat (4) @(negedge clk);
        Reset = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_tests++; if (LD650_1DACData !== 12'd0 || LD650_2DACData !== 12'd0) begin n_fail++; $display("FAIL reset_data got=%0d/%0d exp=0/0", LD650_1DACData, LD650_2DACData); end
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
        n_tests++; if (ch1_at_target !== 1'b1 || ch2_at_target !== 1'b1) begin n_fail++; $display("FAIL reset_at_target got=%b%b exp=11", ch1_at_target, ch2_at_target); end
        init_req++;
        wait_init(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL init_wait got=timeout exp=done"); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL init_ready got=%b exp=1", ready); end
        n_tests++; if (wr_ch.size() != 0 || off_cnt != 0) begin n_fail++; $display("FAIL init_no_flags got=%0d/%0d exp=0/0", wr_ch.size(), off_cnt); end
        m_cur1 = 0; m_cur2 = 0; m_last = 2;
    endtask

    task automatic test_ramp_ch1();
        bit ok;
        int b = wr_ch.size();
        model_build(m_cur1, 200, m_cur2, m_cur2, m_last);
        set_targets(1'b1, 12'd200, 1'b0, 12'd0);
        wait_ready(3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ramp_ready got=timeout exp=ready"); end
        n_tests++; if (wr_ch.size() - b != exp_ch.size()) begin n_fail++; $display("FAIL ramp_count got=%0d exp=%0d", wr_ch.size() - b, exp_ch.size()); end
        for (int i = 0; i < exp_ch.size(); i++) begin
            n_tests++;
            if (b + i >= wr_ch.size()) begin n_fail++; $display("FAIL ramp_write[%0d] got=none exp=ch%0d:%0d", i, exp_ch[i], exp_data[i]); end
            else if (wr_ch[b+i] != exp_ch[i] || int'(wr_data[b+i]) != exp_data[i]) begin
                n_fail++; $display("FAIL ramp_write[%0d] got=ch%0d:%0d exp=ch%0d:%0d", i, wr_ch[b+i], wr_data[b+i], exp_ch[i], exp_data[i]);
            end
        end
        for (int i = b + 1; i < wr_ch.size(); i++) begin
            n_tests++; if (wr_cyc[i] - wr_cyc[i-1] < GAP_I) begin n_fail++; $display("FAIL ramp_spacing got=%0d exp>=%0d", wr_cyc[i] - wr_cyc[i-1], GAP_I); end
        end
        n_tests++; if (ch1_at_target !== 1'b1 || LD650_1DACData !== 12'd200) begin n_fail++; $display("FAIL ramp_final got=%b/%0d exp=1/200", ch1_at_target, LD650_1DACData); end
        m_cur1 = 200;
    endtask

    task automatic test_both();
        bit ok;
        int b;
        do_reset_init(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL both_init got=timeout exp=done"); end
        b = wr_ch.size();
        model_build(m_cur1, 100, m_cur2, 100, m_last);
        set_targets(1'b1, 12'd100, 1'b1, 12'd100);
        wait_ready(3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL both_ready got=timeout exp=ready"); end
        n_tests++; if (wr_ch.size() - b != exp_ch.size()) begin n_fail++; $display("FAIL both_count got=%0d exp=%0d", wr_ch.size() - b, exp_ch.size()); end
        for (int i = 0; i < exp_ch.size(); i++) begin
            n_tests++;
            if (b + i >= wr_ch.size()) begin n_fail++; $display("FAIL both_write[%0d] got=none exp=ch%0d:%0d", i, exp_ch[i], exp_data[i]); end
            else if (wr_ch[b+i] != exp_ch[i] || int'(wr_data[b+i]) != exp_data[i]) begin
                n_fail++; $display("FAIL both_write[%0d] got=ch%0d:%0d exp=ch%0d:%0d", i, wr_ch[b+i], wr_data[b+i], exp_ch[i], exp_data[i]);
            end
        end
        n_tests++; if (LD650_1DACData !== 12'd100 || LD650_2DACData !== 12'd100) begin n_fail++; $display("FAIL both_final got=%0d/%0d exp=100/100", LD650_1DACData, LD650_2DACData); end
        m_cur1 = 100; m_cur2 = 100;
    endtask

    task automatic test_laser_off();
        bit ok;
        int b = wr_ch.size();
        int off0 = off_cnt;
        set_targets(1'b0, 12'd0, 1'b1, 12'd300);
        wait_log(b + 1, 200, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL off_ch2_start got=timeout exp=start"); end
        @(negedge clk);
        laser_off_req = 1'b1;
        @(negedge clk);
        laser_off_req = 1'b0;
        wait_ready(1000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL off_ready got=timeout exp=ready"); end
        n_tests++; if (wr_ch.size() - b != 1) begin n_fail++; $display("FAIL off_writes got=%0d exp=1", wr_ch.size() - b); end
        n_tests++; if (wr_ch.size() > b && (wr_ch[b] != 2 || wr_data[b] !== 12'd164)) begin n_fail++; $display("FAIL off_ch2_write got=ch%0d:%0d exp=ch2:164", wr_ch[b], wr_data[b]); end
        n_tests++; if (off_cnt - off0 != 1) begin n_fail++; $display("FAIL off_pulses got=%0d exp=1", off_cnt - off0); end
        n_tests++; if (wr_ch.size() > b && off_cyc - wr_cyc[b] < GAP_I) begin n_fail++; $display("FAIL off_after_write got=%0d exp>=%0d", off_cyc - wr_cyc[b], GAP_I); end
        n_tests++; if (LD650_1DACData !== 12'd0 || LD650_2DACData !== 12'd0) begin n_fail++; $display("FAIL off_data got=%0d/%0d exp=0/0", LD650_1DACData, LD650_2DACData); end
        n_tests++; if (ch1_at_target !== 1'b1 || ch2_at_target !== 1'b1) begin n_fail++; $display("FAIL off_at_target got=%b%b exp=11", ch1_at_target, ch2_at_target); end
        m_cur1 = 0; m_cur2 = 0; m_last = 2;
    endtask

    task automatic test_timeout();
        bit ok;
        int b = wr_ch.size();
        int t0;
        ack_en = 1'b0;
        set_targets(1'b1, 12'd50, 1'b0, 12'd0);
        wait_log(b + 1, 200, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_start got=timeout exp=start"); end
        t0 = (wr_cyc.size() > b) ? wr_cyc[b] : cyc;
        while (cyc < t0 + TMO_I - 5) @(negedge clk);
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early got=%b exp=0", err_timeout); end
        while (cyc < t0 + TMO_I + 5) @(negedge clk);
        n_tests++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_err got=%b exp=1", err_timeout); end
        n_tests++; if (ch1_at_target !== 1'b0) begin n_fail++; $display("FAIL tmo_cur_kept got=%b exp=0", ch1_at_target); end
        ack_en = 1'b1;
        wait_ready(1000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_ready got=timeout exp=ready"); end
        n_tests++; if (wr_ch.size() - b != 2) begin n_fail++; $display("FAIL tmo_retry_count got=%0d exp=2", wr_ch.size() - b); end
        n_tests++; if (wr_ch.size() > b + 1 && (wr_ch[b+1] != 1 || wr_data[b+1] !== 12'd50 || wr_cyc[b+1] - t0 < TMO_I + GAP_I)) begin
            n_fail++; $display("FAIL tmo_retry got=ch%0d:%0d@%0d exp=ch1:50@>=%0d", wr_ch[b+1], wr_data[b+1], wr_cyc[b+1] - t0, TMO_I + GAP_I);
        end
        n_tests++; if (err_timeout !== 1'b1 || ch1_at_target !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got=%b/%b exp=1/1", err_timeout, ch1_at_target); end
        m_cur1 = 50; m_last = 1;
    endtask

    task automatic test_retarget();
        bit ok;
        int b;
        do_reset_init(ok);
        n_tests++; if (!ok || err_timeout !== 1'b0) begin n_fail++; $display("FAIL retarget_reset got=%b/%b exp=1/0", ok, err_timeout); end
        b = wr_ch.size();
        set_targets(1'b1, 12'd300, 1'b0, 12'd0);
        wait_log(b + 2, 400, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL retarget_two got=timeout exp=two_writes"); end
        repeat (8) @(negedge clk);
        set_targets(1'b1, 12'd0, 1'b0, 12'd0);
        wait_ready(1000, ok);
        exp_data.delete();
        exp_data.push_back(64); exp_data.push_back(128); exp_data.push_back(64); exp_data.push_back(0);
        n_tests++; if (!ok || wr_ch.size() - b != 4) begin n_fail++; $display("FAIL retarget_count got=%0d exp=4", wr_ch.size() - b); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (b + i >= wr_ch.size()) begin n_fail++; $display("FAIL retarget_write[%0d] got=none exp=ch1:%0d", i, exp_data[i]); end
            else if (wr_ch[b+i] != 1 || int'(wr_data[b+i]) != exp_data[i]) begin
                n_fail++; $display("FAIL retarget_write[%0d] got=ch%0d:%0d exp=ch1:%0d", i, wr_ch[b+i], wr_data[b+i], exp_data[i]);
            end
        end
        m_cur1 = 0; m_last = 1;
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 6; it++) begin
            int b = wr_ch.size();
            bit s1, s2;
            int t1, t2, n1, n2;
            t1 = (it == 0) ? 4095 : (it == 1) ? 0 : int'($urandom_range(0, 4095));
            t2 = (it == 0) ? 0 : (it == 1) ? 4095 : int'($urandom_range(0, 4095));
            s1 = (it < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            s2 = (it < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            if (!s1 && !s2) s1 = 1'b1;
            n1 = s1 ? t1 : m_cur1;
            n2 = s2 ? t2 : m_cur2;
            model_build(m_cur1, n1, m_cur2, n2, m_last);
            set_targets(s1, 12'(t1), s2, 12'(t2));
            wait_ready(8000, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL rand%0d_ready got=timeout exp=ready", it); end
            n_tests++; if (wr_ch.size() - b != exp_ch.size()) begin n_fail++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, wr_ch.size() - b, exp_ch.size()); end
            for (int i = 0; i < exp_ch.size(); i++) begin
                n_tests++;
                if (b + i >= wr_ch.size()) begin n_fail++; $display("FAIL rand%0d_write[%0d] got=none exp=ch%0d:%0d", it, i, exp_ch[i], exp_data[i]); end
                else if (wr_ch[b+i] != exp_ch[i] || int'(wr_data[b+i]) != exp_data[i]) begin
                    n_fail++; $display("FAIL rand%0d_write[%0d] got=ch%0d:%0d exp=ch%0d:%0d", it, i, wr_ch[b+i], wr_data[b+i], exp_ch[i], exp_data[i]);
                end
            end
            n_tests++; if (int'(LD650_1DACData) != n1 || int'(LD650_2DACData) != n2 || ch1_at_target !== 1'b1 || ch2_at_target !== 1'b1) begin
                n_fail++; $display("FAIL rand%0d_final got=%0d/%0d exp=%0d/%0d", it, LD650_1DACData, LD650_2DACData, n1, n2);
            end
            m_cur1 = n1; m_cur2 = n2;
        end
    endtask

    task automatic test_flag_exclusive();
        n_tests++; if (multi_cnt != 0) begin n_fail++; $display("FAIL flag_exclusive got=%0d exp=0", multi_cnt); end
    endtask

    initial begin
        test_reset();
        test_ramp_ch1();
        test_both();
        test_laser_off();
        test_timeout();
        test_retarget();
        test_random();
        test_flag_exclusive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
